// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory. Assembles a little-endian byte
// stream into 32-bit instruction words and writes them into IMEM, one word
// per WRITE cycle. The core is held in reset (core_hold) until a load
// finishes cleanly.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a trailing little-endian checksum word follows the data
//   words. It is compared against the XOR of all written words. A mismatch
//   sets error and keeps core_hold high after DONE. When undefined, there is
//   no CHECK state and error is tied low.
//
// Ports:
//   clk        in   single clock
//   reset      in   synchronous, active-high reset
//   start      in   one-cycle load request, only honoured in IDLE
//   len        in   number of words to load (0 .. 2**ADDR_WIDTH), latched with start
//   s_data     in   stream byte
//   s_valid    in   s_data valid
//   s_ready    out  loader accepts a byte (transfer on s_valid && s_ready)
//   mem_we     out  IMEM write enable
//   mem_addr   out  IMEM word address
//   mem_data   out  IMEM write data
//   busy       out  load in progress (LOAD, WRITE, CHECK)
//   done       out  one-cycle pulse when a load finishes
//   error      out  checksum mismatch flag
//   core_hold  out  core reset request
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int          ADDR_WIDTH = 9,
   parameter int          DATA_WIDTH = 32,   // fixed at 4 bytes
   parameter int unsigned START_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  core_hold
);

   localparam logic [ADDR_WIDTH-1:0] START_W = ADDR_WIDTH'(START_ADDR);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
`endif

   state_t                r_state;
   state_t                w_state_next;

   logic [ADDR_WIDTH:0]   r_remaining;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_byte_idx;
   logic [DATA_WIDTH-1:0] r_word;       // partially assembled word
   logic [DATA_WIDTH-1:0] r_mem_data;   // last complete data word
   logic                  r_hold;

   logic                  w_rx_phase;
   logic                  w_accept;
   logic                  w_last_byte;
   logic                  w_error;
   logic [3:0]            w_lane_en;
   logic [DATA_WIDTH-1:0] w_full_word;  // r_word with the current byte merged in

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic                  r_error;
   logic [DATA_WIDTH-1:0] r_xor;
   assign w_rx_phase = (r_state == S_LOAD) || (r_state == S_CHECK);
   assign w_error    = r_error;
`else
   assign w_rx_phase = (r_state == S_LOAD);
   assign w_error    = 1'b0;
`endif

   assign s_ready     = w_rx_phase;
   assign w_accept    = s_valid && w_rx_phase;
   assign w_last_byte = w_accept && (r_byte_idx == 2'd3);

   // Byte lane k of the word takes stream byte k (little-endian). The merged
   // word lets the 4th byte reach r_mem_data / the checksum compare directly.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
         assign w_lane_en[gi]             = w_accept && (r_byte_idx == 2'(gi));
         assign w_full_word[8*gi +: 8]    = w_lane_en[gi] ? s_data : r_word[8*gi +: 8];
      end
   endgenerate

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------- next state and FSM outputs
   always_comb begin
      w_state_next = r_state;
      mem_we       = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      core_hold    = r_hold;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  w_state_next = S_CHECK;
`else
                  w_state_next = S_DONE;
`endif
               end else begin
                  w_state_next = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            busy = 1'b1;
            if (w_last_byte) begin
               w_state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            busy   = 1'b1;
            // A reset landing on the WRITE cycle must not commit the word.
            mem_we = !reset;
            if (r_remaining == (ADDR_WIDTH+1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               w_state_next = S_CHECK;
`else
               w_state_next = S_DONE;
`endif
            end else begin
               w_state_next = S_LOAD;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            busy = 1'b1;
            if (w_last_byte) begin
               w_state_next = S_DONE;
            end
         end
`endif
         S_DONE: begin
            done         = 1'b1;
            // A failed checksum keeps the core parked in reset.
            core_hold    = w_error;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         r_remaining <= '0;
         r_addr      <= START_W;
         r_byte_idx  <= 2'd0;
         r_word      <= '0;
         r_mem_data  <= '0;
         r_hold      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_error     <= 1'b0;
         r_xor       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_remaining <= len;
                  r_addr      <= START_W;
                  r_byte_idx  <= 2'd0;
                  r_word      <= '0;
                  r_hold      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_error     <= 1'b0;
                  r_xor       <= '0;
`endif
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_word     <= w_full_word;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (w_last_byte) begin
                     r_mem_data <= w_full_word;
                  end
               end
            end
            S_WRITE: begin
               // Address wraps naturally at 2**ADDR_WIDTH.
               r_addr      <= r_addr + 1'b1;
               r_remaining <= r_remaining - 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               r_xor       <= r_xor ^ r_mem_data;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
               // Checksum bytes share the assembly path but never reach IMEM.
               if (w_accept) begin
                  r_word     <= w_full_word;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (w_last_byte) begin
                     r_error <= (w_full_word != r_xor);
                  end
               end
            end
`endif
            S_DONE: begin
               r_hold <= w_error;
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_addr = r_addr;
   assign mem_data = r_mem_data;
   assign error    = w_error;

endmodule
